// File: rtl/pipelined_adder.sv
// Pipelined adder/subtractor. The carry chain is split into STAGES chunks of
// CW bits each. Each pipeline stage adds one chunk and registers the partial
// sum and the chunk carry. The upper operand chunks that are still to be
// added, and the lower sum chunks that are already finished, travel down the
// pipeline together with a per-stage valid bit.
// Flow control is a global stall: every stage advances only when the output
// register is empty or is being consumed on the same edge.
module pipelined_adder #(
  parameter int WIDTH  = 8,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);

  localparam int CW   = WIDTH / STAGES;
  localparam int LAST = STAGES - 1;

  // Writes chunk 'chunk' into slot 'idx' of 'base' and leaves the other bits unchanged.
  function automatic logic [WIDTH-1:0] insert_chunk(input logic [WIDTH-1:0] base,
                                                    input logic [CW-1:0]    chunk,
                                                    input int               idx);
    logic [WIDTH-1:0] r;
    r = base;
    r[idx*CW +: CW] = chunk;
    return r;
  endfunction

  // Global pipeline enable. It is also the upstream ready.
  logic             advance;
  // Second operand after the optional inversion for subtraction.
  logic [WIDTH-1:0] b_eff;

  // Registers of each stage. Element k holds the state after stage k+1.
  logic             valid_reg [STAGES];
  logic             carry_reg [STAGES];
  logic [WIDTH-1:0] a_reg     [STAGES];
  logic [WIDTH-1:0] b_reg     [STAGES];
  logic [WIDTH-1:0] sum_reg   [STAGES];
  logic             overflow_reg;

  // Combinational inputs of each stage and the result it would register.
  logic             stage_valid [STAGES];
  logic             stage_cin   [STAGES];
  logic [WIDTH-1:0] stage_a     [STAGES];
  logic [WIDTH-1:0] stage_b     [STAGES];
  logic [WIDTH-1:0] stage_sum   [STAGES];
  logic [CW:0]      chunk_res   [STAGES];
  logic [WIDTH-1:0] sum_next    [STAGES];
  logic             overflow_next;

  // Stall when a valid result is waiting and the consumer is not taking it.
  assign advance  = out_ready || !out_valid;
  assign in_ready = advance;

  // Subtraction is computed as a + ~b + 1. The +1 enters as the stage-1 carry-in.
  assign b_eff = sub ? ~b : b;

  // Per-stage chunk adders. Stage 1 takes its inputs from the ports. Each later
  // stage takes its inputs from the registers of the stage before it.
  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    if (gi == 0) begin : g_first
      assign stage_valid[gi] = in_valid;
      assign stage_cin[gi]   = sub;
      assign stage_a[gi]     = a;
      assign stage_b[gi]     = b_eff;
      assign stage_sum[gi]   = '0;
    end else begin : g_chain
      assign stage_valid[gi] = valid_reg[gi-1];
      assign stage_cin[gi]   = carry_reg[gi-1];
      assign stage_a[gi]     = a_reg[gi-1];
      assign stage_b[gi]     = b_reg[gi-1];
      assign stage_sum[gi]   = sum_reg[gi-1];
    end

    // Chunk gi of the operands plus the carry from the stage below.
    assign chunk_res[gi] = {1'b0, stage_a[gi][gi*CW +: CW]}
                         + {1'b0, stage_b[gi][gi*CW +: CW]}
                         + {{CW{1'b0}}, stage_cin[gi]};

    assign sum_next[gi] = insert_chunk(stage_sum[gi], chunk_res[gi][CW-1:0], gi);
  end

  // Signed overflow: the operands have the same sign and the result sign differs.
  assign overflow_next = (stage_a[LAST][WIDTH-1] == stage_b[LAST][WIDTH-1]) &&
                         (sum_next[LAST][WIDTH-1] != stage_a[LAST][WIDTH-1]);

  // Advance all stages together. Bubbles move through as valid = 0. Data
  // registers load only with a valid transaction, so the outputs keep the last
  // result while out_valid is 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_reg[k] <= 1'b0;
        carry_reg[k] <= 1'b0;
        a_reg[k]     <= '0;
        b_reg[k]     <= '0;
        sum_reg[k]   <= '0;
      end
      overflow_reg <= 1'b0;
    end else if (advance) begin
      for (int k = 0; k < STAGES; k++) begin
        valid_reg[k] <= stage_valid[k];
        if (stage_valid[k]) begin
          carry_reg[k] <= chunk_res[k][CW];
          a_reg[k]     <= stage_a[k];
          b_reg[k]     <= stage_b[k];
          sum_reg[k]   <= sum_next[k];
        end
      end
      if (stage_valid[LAST]) begin
        overflow_reg <= overflow_next;
      end
    end
  end

  assign out_valid = valid_reg[LAST];
  assign sum       = sum_reg[LAST];
  assign carry     = carry_reg[LAST];
  assign overflow  = overflow_reg;

endmodule

// File: tb/tb_pipelined_adder.sv
// Scoreboard bench for pipelined_adder. It instantiates three configurations:
// 8/2, 16/4 and 32/1. Accepted transactions push a reference result computed
// with plain signed/unsigned arithmetic. A negedge monitor pops a reference
// result whenever a result is consumed, compares it, and also checks that the
// outputs hold during stalls.
module tb_pipelined_adder;

  typedef struct packed {
    logic [31:0] sum;
    logic        carry;
    logic        ovf;
  } resp_t;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [2:0]      in_valid_s  = '0;
  logic [2:0]      in_ready_s;
  logic [2:0][31:0] a_s        = '0;
  logic [2:0][31:0] b_s        = '0;
  logic [2:0]      sub_s       = '0;
  logic [2:0]      out_valid_s;
  logic [2:0]      out_ready_s = '1;
  logic [2:0][31:0] sum_s;
  logic [2:0]      carry_s;
  logic [2:0]      ovf_s;

  int n_cmp = 0;
  int n_bad = 0;

  resp_t       exp_q [3][$];
  logic        hold_prev [3];
  logic [31:0] held_sum  [3];
  logic        held_c    [3];
  logic        held_o    [3];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    localparam int W = (gi == 0) ? 8 : (gi == 1) ? 16 : 32;
    localparam int S = (gi == 0) ? 2 : (gi == 1) ? 4 : 1;
    pipelined_adder #(.WIDTH(W), .STAGES(S)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid_s[gi]),
      .in_ready  (in_ready_s[gi]),
      .a         (a_s[gi][W-1:0]),
      .b         (b_s[gi][W-1:0]),
      .sub       (sub_s[gi]),
      .out_valid (out_valid_s[gi]),
      .out_ready (out_ready_s[gi]),
      .sum       (sum_s[gi][W-1:0]),
      .carry     (carry_s[gi]),
      .overflow  (ovf_s[gi])
    );
    if (W < 32) begin : g_pad
      assign sum_s[gi][31:W] = '0;
    end
  end

  function automatic int wof(input int i);
    return (i == 0) ? 8 : (i == 1) ? 16 : 32;
  endfunction

  // Reference model: exact integer arithmetic on unsigned and signed views.
  function automatic resp_t model(input int w, input logic [31:0] a, input logic [31:0] b,
                                  input logic sub);
    resp_t  r;
    longint m, ua, ub, sa, sb, res_u, res_s, lim;
    m   = (longint'(1) << w) - 1;
    lim = longint'(1) << (w - 1);
    ua  = longint'(a) & m;
    ub  = longint'(b) & m;
    sa  = (ua >= lim) ? ua - (m + 1) : ua;
    sb  = (ub >= lim) ? ub - (m + 1) : ub;
    if (!sub) begin
      res_u   = ua + ub;
      r.carry = (res_u > m);
      res_s   = sa + sb;
    end else begin
      res_u   = ua - ub;
      r.carry = (ua >= ub);
      res_s   = sa - sb;
    end
    r.sum = 32'(res_u & m);
    r.ovf = (res_s >= lim) || (res_s < -lim);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor and scoreboard.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        exp_q[i].delete();
        hold_prev[i] = 1'b0;
      end else begin
        if (hold_prev[i]) begin
          n_cmp++;
          if (!out_valid_s[i] || sum_s[i] !== held_sum[i] || carry_s[i] !== held_c[i] ||
              ovf_s[i] !== held_o[i]) begin
            n_bad++;
            $display("FAIL hold[%0d]: got v=%b sum=%h c=%b o=%b expected v=1 sum=%h c=%b o=%b",
                     i, out_valid_s[i], sum_s[i], carry_s[i], ovf_s[i],
                     held_sum[i], held_c[i], held_o[i]);
          end
        end
        if (out_valid_s[i] && out_ready_s[i]) begin
          n_cmp++;
          if (exp_q[i].size() == 0) begin
            n_bad++;
            $display("FAIL result[%0d]: got unexpected sum=%h expected no result", i, sum_s[i]);
          end else begin
            resp_t e;
            e = exp_q[i].pop_front();
            if (sum_s[i] !== e.sum || carry_s[i] !== e.carry || ovf_s[i] !== e.ovf) begin
              n_bad++;
              $display("FAIL result[%0d]: got sum=%h c=%b o=%b expected sum=%h c=%b o=%b",
                       i, sum_s[i], carry_s[i], ovf_s[i], e.sum, e.carry, e.ovf);
            end
          end
        end
        hold_prev[i] = out_valid_s[i] && !out_ready_s[i];
        held_sum[i]  = sum_s[i];
        held_c[i]    = carry_s[i];
        held_o[i]    = ovf_s[i];
        if (in_valid_s[i] && in_ready_s[i]) begin
          exp_q[i].push_back(model(wof(i), a_s[i], b_s[i], sub_s[i]));
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One isolated transaction on the 8/2 instance with a latency check.
  task automatic run_one(input string name, input logic [7:0] a, input logic [7:0] b,
                         input logic sub, input logic [7:0] es, input logic ec, input logic eo);
    in_valid_s[0] = 1'b1;
    a_s[0] = {24'd0, a};
    b_s[0] = {24'd0, b};
    sub_s[0] = sub;
    out_ready_s[0] = 1'b1;
    step();
    in_valid_s[0] = 1'b0;
    check({name, "_early_valid"}, {31'd0, out_valid_s[0]}, 32'd0);
    step();
    check({name, "_valid"}, {31'd0, out_valid_s[0]}, 32'd1);
    check({name, "_sum"}, sum_s[0], {24'd0, es});
    check({name, "_carry_ovf"}, {30'd0, carry_s[0], ovf_s[0]}, {30'd0, ec, eo});
    step();
  endtask

  initial begin
    bit all_empty;
    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", {29'd0, out_valid_s}, 32'd0);
    check("rst_in_ready", {29'd0, in_ready_s}, 32'h7);
    check("rst_sum", sum_s[0], 32'd0);
    check("rst_carry_ovf", {30'd0, carry_s[0], ovf_s[0]}, 32'd0);
    rst = 1'b0;
    step();

    // Arithmetic corner cases.
    run_one("add_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    run_one("add_7f_01", 8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    run_one("add_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1);
    run_one("sub_05_07", 8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
    run_one("sub_80_01", 8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Back-to-back transactions with a three-cycle output stall.
    sub_s[0] = 1'b0;
    in_valid_s[0] = 1'b1; a_s[0] = 32'h10; b_s[0] = 32'h01;
    step();
    a_s[0] = 32'h20; b_s[0] = 32'h02;
    step();
    a_s[0] = 32'h30; b_s[0] = 32'h03;
    out_ready_s[0] = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stall_in_ready", {31'd0, in_ready_s[0]}, 32'd0);
      check("stall_sum", sum_s[0], 32'h11);
      step();
    end
    out_ready_s[0] = 1'b1;
    #1;
    check("stall_release_sum", sum_s[0], 32'h11);
    check("stall_release_ready", {31'd0, in_ready_s[0]}, 32'd1);
    step();
    in_valid_s[0] = 1'b0;
    check("seq_sum_22", {out_valid_s[0], sum_s[0][30:0]}, 32'h80000022);
    step();
    check("seq_sum_33", {out_valid_s[0], sum_s[0][30:0]}, 32'h80000033);
    step();
    check("seq_drained", {31'd0, out_valid_s[0]}, 32'd0);

    // Reset with two transactions in flight.
    in_valid_s[0] = 1'b1; a_s[0] = 32'h44; b_s[0] = 32'h11;
    step();
    a_s[0] = 32'h55; b_s[0] = 32'h22;
    step();
    in_valid_s[0] = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_mid_out_valid", {31'd0, out_valid_s[0]}, 32'd0);
    check("rst_mid_sum", sum_s[0], 32'd0);
    check("rst_mid_in_ready", {31'd0, in_ready_s[0]}, 32'd1);
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("rst_no_stale", {31'd0, out_valid_s[0]}, 32'd0);
    end
    run_one("post_rst_01_01", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0, 1'b0);

    // Randomized traffic on all three configurations.
    for (int c = 0; c < 1500; c++) begin
      for (int i = 0; i < 3; i++) begin
        in_valid_s[i]  = ($urandom_range(0, 3) != 0);
        a_s[i]         = $urandom;
        b_s[i]         = $urandom;
        sub_s[i]       = 1'($urandom_range(0, 1));
        out_ready_s[i] = ($urandom_range(0, 3) != 0);
      end
      step();
    end
    in_valid_s  = '0;
    out_ready_s = '1;

    // Drain with a bounded wait.
    all_empty = 1'b0;
    for (int c = 0; c < 60 && !all_empty; c++) begin
      step();
      all_empty = (exp_q[0].size() == 0) && (exp_q[1].size() == 0) && (exp_q[2].size() == 0);
    end
    for (int i = 0; i < 3; i++) begin
      check($sformatf("drain_queue[%0d]", i), exp_q[i].size(), 32'd0);
      check($sformatf("drain_valid[%0d]", i), {31'd0, out_valid_s[i]}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
